// File: rtl/redmule_z_drain_buffer.sv
// RedMulE Z drain buffer: captures result columns into two ping-pong
// tile banks and drains them row by row to the output streamer.
module redmule_z_drain_buffer #(
    parameter int unsigned DW       = 288,
    parameter int unsigned FpFormat = 2,
    parameter int unsigned Width    = 12,
    localparam int unsigned BITW = (FpFormat == 0) ? 32 :
                                   (FpFormat == 1) ? 64 :
                                   (FpFormat == 3) ? 8  : 16,
    localparam int unsigned W  = Width,
    localparam int unsigned D  = DW / BITW,
    localparam int unsigned CW = $clog2(D) + 1,
    localparam int unsigned RW = $clog2(W) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [CW-1:0]            cfg_cols_i,
    input  logic [RW-1:0]            cfg_rows_i,
    input  logic                     z_valid_i,
    output logic                     z_ready_o,
    input  logic [W-1:0][BITW-1:0]   z_i,
    input  logic                     z_last_i,
    output logic [DW-1:0]            z_o,
    output logic                     z_valid_o,
    input  logic                     z_ready_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     done_o
);

    localparam int unsigned CI = $clog2(D);
    localparam int unsigned RI = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e          state_q, state_d;
    logic [BITW-1:0] mem_q [2][W][D];
    logic [1:0]      occ_q;
    logic [1:0]      last_q;
    logic [CW-1:0]   ccnt_q [2];
    logic            w_bank_q, r_bank_q;
    logic [CW-1:0]   col_q, cols_q;
    logic [RW-1:0]   row_q, rows_q;
    logic            done_q;

    logic accept, close, hs, rel, fin;

    assign accept = z_valid_i && z_ready_o;
    assign close  = accept && ((col_q == cols_q - CW'(1)) || z_last_i);
    assign hs     = z_valid_o && z_ready_i;
    assign rel    = hs && (row_q == rows_q - RW'(1));
    assign fin    = rel && last_q[r_bank_q];

    assign z_valid_o = occ_q[r_bank_q];
    assign full_o    = &occ_q;
    assign empty_o   = ~|occ_q;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // FSM next state: the job ends when its last tile is fully drained
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (accept && z_last_i) state_d = FLUSH;
            FLUSH:   if (fin) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: capture only in RUN into a free bank
    always_comb begin
        z_ready_o = 1'b0;
        done_o    = done_q;
        if (state_q == RUN) z_ready_o = !occ_q[w_bank_q];
    end

    // Bank bookkeeping, capture and drain pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q    <= '0;
            last_q   <= '0;
            ccnt_q   <= '{default: '0};
            w_bank_q <= 1'b0;
            r_bank_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            done_q   <= 1'b0;
        end else if (clear_i) begin
            occ_q    <= '0;
            last_q   <= '0;
            ccnt_q   <= '{default: '0};
            w_bank_q <= 1'b0;
            r_bank_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin;
            if (state_q == IDLE && start_i) begin
                cols_q <= cfg_cols_i;
                rows_q <= cfg_rows_i;
            end
            if (accept) begin
                if (close) begin
                    occ_q[w_bank_q]  <= 1'b1;
                    ccnt_q[w_bank_q] <= col_q + CW'(1);
                    last_q[w_bank_q] <= z_last_i;
                    w_bank_q         <= ~w_bank_q;
                    col_q            <= '0;
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
            if (hs) begin
                if (rel) begin
                    occ_q[r_bank_q] <= 1'b0;
                    r_bank_q        <= ~r_bank_q;
                    row_q           <= '0;
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end
        end
    end

    // Tile storage: data only, validity is tracked by occ/ccnt
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int r = 0; r < W; r++) begin
                mem_q[w_bank_q][r][col_q[CI-1:0]] <= z_i[r];
            end
        end
    end

    // Drain word: lanes beyond the captured column count read zero
    always_comb begin
        z_o = '0;
        if (occ_q[r_bank_q]) begin
            for (int j = 0; j < D; j++) begin
                if (CW'(j) < ccnt_q[r_bank_q]) begin
                    z_o[j*BITW +: BITW] = mem_q[r_bank_q][row_q[RI-1:0]][j];
                end
            end
        end
    end

endmodule

// File: doc/redmule_z_drain_buffer.md
# redmule_z_drain_buffer

Output-side staging buffer for the RedMulE datapath. It captures result column vectors from the systolic array and reorganises them into row-major tiles. It then drains those tiles row by row as DW-bit words to the output streamer over a valid/ready handshake. Two tile banks are ping-ponged so the array can keep producing while the previous tile is drained.

## Interface
- DW, 288: streamer word width in bits.
- FpFormat, fpnew_pkg::FP16: element format; BITW = fpnew_pkg::fp_width(FpFormat).
- Width, ARRAY_WIDTH: array rows W, i.e. elements per captured column.
- D (localparam), DW/BITW: columns per tile, i.e. lanes per output word.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear to reset state, dominant over all other inputs.
- start_i  in  1  pulse; latches cfg_cols_i and cfg_rows_i and leaves IDLE.
- cfg_cols_i  in  $clog2(D)+1  columns per full tile, 1..D.
- cfg_rows_i  in  $clog2(W)+1  rows drained per tile, 1..W.
- z_valid_i  in  1  column valid from the array.
- z_ready_o  out  1  column accepted when z_valid_i && z_ready_o.
- z_i  in  [W-1:0][BITW-1:0]  column; element r belongs to row r.
- z_last_i  in  1  qualifies the accepted column as the final one of the job.
- z_o  out  DW  output word; lane j (bits j*BITW +: BITW) = row r, column j.
- z_valid_o  out  1  output word valid.
- z_ready_i  in  1  streamer ready.
- full_o  out  1  both banks occupied.
- empty_o  out  1  no bank occupied.
- done_o  out  1  one-cycle pulse after the final row of the final tile is handshaken.

## Operation
- Top FSM states:
  - IDLE: z_ready_o=0. Moves to RUN on start_i.
  - RUN: capture enabled. Moves to FLUSH on an accepted column with z_last_i.
  - FLUSH: capture closed, z_ready_o=0. Moves to IDLE once empty_o=1 and the last-tile drain completes; done_o pulses that cycle.
- Per-bank state: occupied bit, captured column count ccnt (1..D), last flag.
- Capture side:
  - Write pointer w_bank and column counter col.
  - z_ready_o = (state==RUN) && !occupied[w_bank].
  - An accepted column is written to bank w_bank, column col, all W rows.
  - The tile closes when col==cfg_cols-1 or z_last_i is set. On close: occupied[w_bank]<=1, ccnt<=col+1, last<=z_last_i, w_bank toggles, col<=0.
  - Otherwise col increments.
- Drain side:
  - Read pointer r_bank and row counter row.
  - z_valid_o = occupied[r_bank].
  - z_o is driven combinationally from bank r_bank, row row.
  - Lanes j >= ccnt[r_bank] are forced to 0. This covers partial last tiles and cfg_cols<D.
  - On handshake: row increments.
  - At row==cfg_rows-1: occupied[r_bank]<=0, r_bank toggles, row<=0. If that bank's last flag is set, the FSM goes to IDLE and done_o pulses.
- Flags: full_o = &occupied; empty_o = ~|occupied.
- Config values are held constant until IDLE; cfg changes outside start_i are ignored.

## Timing
- Reset / clear values: z_ready_o=0, z_valid_o=0, z_o=0, full_o=0, empty_o=1, done_o=0. All pointers and counters are 0, state IDLE.
- Capture-to-drain latency: a column that closes a tile in cycle t gives z_valid_o=1 in cycle t+1.
- Drain throughput: one row per cycle while z_ready_i=1.
- Handshake stability: z_o and z_valid_o remain stable while z_valid_o && !z_ready_i. The occupied bank is never written.
- Bank release: a bank freed by a drain in cycle t is writable from t+1. z_ready_o rises in t+1 with no combinational path from z_ready_i.
- Simultaneous tile close and tile release on different banks in the same cycle are both honoured.
- Both banks full: z_ready_o=0, and capture stalls without data loss.
- z_last_i on the very first column gives a tile with ccnt=1.
- Pointer wrap: all pointers wrap modulo 2 banks.
- clear_i mid-drain: next cycle is reset state and the partial tile is discarded; no done_o.
- Reset mid-operation: same as clear_i, asynchronously.

## Test plan
- FP16, DW=288 (D=18), W=12. cfg_cols=18, cfg_rows=12, 18 columns streamed with col c = {r*256+c}, last on col 17, z_ready_i=1:
  - z_valid_o rises the cycle after col 17.
  - 12 words; word r lane j = r*256+j.
  - done_o pulses the cycle after word 11.
- Backpressure: same job with z_ready_i toggled randomly. Each word is held stable until accepted, and the sequence is identical to the no-backpressure case.
- Ping-pong: 3 full tiles back-to-back with z_ready_i=0 for 60 cycles.
  - full_o=1 and z_ready_o=0 after tile 2 closes.
  - After release, tile 3 is captured and all 36 words arrive in order.
- Partial tile: cfg_cols=10, job of 25 columns (tiles of 10, 10, 5). In the last tile, lanes 5..17 read 0; lanes 10..17 read 0 in every tile.
- cfg_rows=4: only rows 0..3 are emitted per tile (4 words per tile), and the next bank follows immediately.
- clear_i asserted during the 3rd word: the next cycle shows z_valid_o=0, empty_o=1, no done_o, and a new start_i job runs correctly.
